tlc_monitor: RTL and testbench
==============================

// Module: tlc_monitor
// PURPOSE
//   Checker at the receiving end of the tlc light outputs. Samples hwy/cntry/X on each slowclk tick,
//   tracks the expected S0..S4 light sequence, measures per-state dwell, counts completed cycles,
//   flags safety/sequence violations. Sits beside tlc on board and in sim; drives debug LEDs/bench.
// PARAMETERS
//   YDLY   3   min ticks a yellow (S1, S4) must be observed before leaving
//   RDLY   2   min ticks all-red (S2) must be observed before leaving
//   DW     4   dwell counter width (saturating)
//   CW     16  completed-cycle counter width (wrapping)
// PORTS
//   clk       in   1    system clock; all logic on rising edge
//   clr       in   1    synchronous active-high reset
//   slowclk   in   1    tlc slow clock, level; rising edge (detected in clk domain) = one tick
//   X         in   1    country-road car sensor, as seen by tlc
//   hwy       in   2    highway light: 0=RED 1=YELLOW 2=GREEN 3=illegal
//   cntry     in   2    country light, same encoding
//   state_id  out  3    tracked state: 0..4 = S0..S4, 7 = INIT/unsynced
//   dwell     out  DW   ticks observed in current state, incl. first; saturates at all-ones
//   cycles    out  CW   count of S4->S0 transitions, wraps
//   viol      out  1    one-clk pulse on any tick with a violation
//   err       out  1    sticky: set on first violation, cleared only by clr
//   err_code  out  3    code of FIRST violation (held); 0 = none
// BEHAVIOUR
//   Reset: clr=1 at clk edge -> state_id=7, dwell=0, cycles=0, viol=0, err=0, err_code=0, slowclk_d=0.
//     clr mid-run overrides any tick in same cycle; monitor restarts in INIT.
//   Tick: tick = slowclk & ~slowclk_d (slowclk_d registered). Outputs update on the clk edge where
//     tick is true (1 clk latency from slowclk first sampled high). No tick -> all outputs hold, viol=0.
//   Decode of (hwy,cntry): S0=(G,R) S1=(Y,R) S2=(R,R) S3=(R,G) S4=(R,Y). Any other pair = conflict.
//   Legal successors: S0->S1, S1->S2, S2->S3, S3->S4, S4->S0; remaining in same state always legal.
//   Violation codes (several on one tick -> lowest code reported):
//     1 conflict: both roads non-red, or any field == 3
//     2 illegal transition: decoded state neither current nor its successor
//     3 short yellow: leaving S1 or S4 with dwell < YDLY
//     4 short all-red: leaving S2 with dwell < RDLY
//     5 unrequested: S0->S1 while X sampled 0 on the previous tick
//   INIT (state_id=7): on tick, legal sample -> that state, dwell=1, no transition/dwell checks;
//     conflict -> code 1, stay INIT.
//   Tracked state, on tick:
//     same state -> dwell+1 (saturate at 2^DW-1)
//     legal successor -> run checks 3/4/5, enter new state, dwell=1; S4->S0 also cycles+1
//     illegal legal-code state -> code 2, resync to observed state, dwell=1
//     conflict -> code 1, state_id=7 (INIT), dwell=0
//   Violation tick: viol=1 for that one clk; if err==0 then err=1 and err_code=code, else code held.
//   X history: prev_X register updated every tick (also in INIT); reset value 0.
// TESTING
//   T1 clr 100ns, then legal sequence S0x3,S1x3,S2x2,S3x3,S4x3,S0, X=1 before S0 exit
//      -> err=0, cycles=1, state_id 0, dwell=1 after last tick.
//   T2 from S0 drive (G,G) -> viol pulse, err=1, err_code=1, state_id=7; next legal (G,R) -> state 0.
//   T3 S1 held 2 ticks (YDLY=3) then S2 -> err_code=3; subsequent S2 1 tick then S3 -> viol, code stays 3.
//   T4 S0 with X=0 on every tick, then S1 -> err_code=5; S0 directly to S3 -> err_code=2.
//   T5 hold S2 20 ticks -> dwell saturates at 15; clr asserted same clk as a tick -> all outputs reset.
//   T6 slowclk high for many clk cycles -> exactly one tick per rising edge (dwell +1 only).

Source files
------------

// File: rtl/tlc_monitor.sv
// rtl/tlc_monitor.sv - traffic-light sequence monitor sampling tlc outputs on slowclk ticks
//
// Purpose: tracks the S0..S4 light sequence seen on hwy/cntry, measures per-state
//   dwell, counts completed cycles and flags safety / sequence violations.
// Ports:
//   clk       in   system clock, rising edge
//   clr       in   synchronous active-high reset
//   slowclk   in   tlc slow clock level; rising edge seen in clk domain = one tick
//   X         in   country-road car sensor
//   hwy       in   highway light (0=R 1=Y 2=G 3=illegal)
//   cntry     in   country light, same encoding
//   state_id  out  tracked state 0..4, 7 = INIT/unsynced
//   dwell     out  ticks in current state (saturating)
//   cycles    out  completed S4->S0 transitions (wrapping)
//   viol      out  one-clk pulse on a violating tick
//   err       out  sticky violation flag
//   err_code  out  code of the first violation
module tlc_monitor #(
  parameter int YDLY = 3,
  parameter int RDLY = 2,
  parameter int DW   = 4,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          slowclk,
  input  logic          X,
  input  logic [1:0]    hwy,
  input  logic [1:0]    cntry,
  output logic [2:0]    state_id,
  output logic [DW-1:0] dwell,
  output logic [CW-1:0] cycles,
  output logic          viol,
  output logic          err,
  output logic [2:0]    err_code
);

  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    INIT = 3'd7
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_dwell;
  logic [CW-1:0]   r_cycles;
  logic            r_viol;
  logic            r_err;
  logic [2:0]      r_err_code;
  logic            r_slowclk_d;
  logic            r_prev_x;

  logic            w_tick;
  logic            w_conflict;
  state_t          w_obs;
  state_t          w_succ;
  state_t          w_nstate;
  logic [DW-1:0]   w_ndwell;
  logic [2:0]      w_code;
  logic            w_cyc_inc;

  assign w_tick = slowclk & ~r_slowclk_d;

  // Decode the light pair; anything outside the five legal pairs is a conflict.
  always_comb begin
    w_conflict = 1'b0;
    w_obs      = INIT;
    case ({hwy, cntry})
      4'b10_00: w_obs = S0;
      4'b01_00: w_obs = S1;
      4'b00_00: w_obs = S2;
      4'b00_10: w_obs = S3;
      4'b00_01: w_obs = S4;
      default:  w_conflict = 1'b1;
    endcase
  end

  assign w_succ = (r_state == S4) ? S0 : state_t'(r_state + 3'd1);

  // Next tracked state/dwell and violation code for the current sample.
  // Checks 3/4/5 apply to mutually exclusive source states, so at most one fires.
  always_comb begin
    w_nstate  = r_state;
    w_ndwell  = r_dwell;
    w_code    = 3'd0;
    w_cyc_inc = 1'b0;
    if (r_state == INIT) begin
      if (w_conflict) begin
        w_code = 3'd1;
      end else begin
        w_nstate = w_obs;
        w_ndwell = DW'(1);
      end
    end else if (w_conflict) begin
      w_code   = 3'd1;
      w_nstate = INIT;
      w_ndwell = '0;
    end else if (w_obs == r_state) begin
      w_ndwell = (r_dwell == {DW{1'b1}}) ? r_dwell : r_dwell + DW'(1);
    end else if (w_obs == w_succ) begin
      if ((r_state == S1 || r_state == S4) && r_dwell < DW'(YDLY))
        w_code = 3'd3;
      else if (r_state == S2 && r_dwell < DW'(RDLY))
        w_code = 3'd4;
      else if (r_state == S0 && !r_prev_x)
        w_code = 3'd5;
      w_cyc_inc = (r_state == S4);
      w_nstate  = w_obs;
      w_ndwell  = DW'(1);
    end else begin
      // Out-of-order legal pattern: report and resync to what is observed.
      w_code   = 3'd2;
      w_nstate = w_obs;
      w_ndwell = DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= INIT;
      r_dwell     <= '0;
      r_cycles    <= '0;
      r_viol      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 3'd0;
      r_slowclk_d <= 1'b0;
      r_prev_x    <= 1'b0;
    end else begin
      r_slowclk_d <= slowclk;
      r_viol      <= 1'b0;
      if (w_tick) begin
        r_state  <= w_nstate;
        r_dwell  <= w_ndwell;
        r_prev_x <= X;
        if (w_cyc_inc) r_cycles <= r_cycles + CW'(1);
        r_viol <= (w_code != 3'd0);
        // Only the first violation is latched; later codes are ignored.
        if (w_code != 3'd0 && !r_err) begin
          r_err      <= 1'b1;
          r_err_code <= w_code;
        end
      end
    end
  end

  assign state_id = r_state;
  assign dwell    = r_dwell;
  assign cycles   = r_cycles;
  assign viol     = r_viol;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule

// File: tb/tb_tlc_monitor.sv
// tb/tb_tlc_monitor.sv - self-checking bench for tlc_monitor
module tb_tlc_monitor;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        slowclk = 1'b0;
  logic        X = 1'b0;
  logic [1:0]  hwy = 2'd0;
  logic [1:0]  cntry = 2'd0;
  logic [2:0]  state_id;
  logic [3:0]  dwell;
  logic [15:0] cycles;
  logic        viol;
  logic        err;
  logic [2:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Light pairs per state, index = state number: {hwy, cntry}
  logic [1:0] pat_h [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
  logic [1:0] pat_c [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1};

  // Reference model state
  int m_state, m_dwell, m_cycles, m_viol, m_err, m_code, m_prevx;

  tlc_monitor dut (
    .clk(clk), .clr(clr), .slowclk(slowclk), .X(X), .hwy(hwy), .cntry(cntry),
    .state_id(state_id), .dwell(dwell), .cycles(cycles), .viol(viol),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"}, 32'(state_id), 32'(m_state));
    chk({tag, ".dwell"}, 32'(dwell), 32'(m_dwell));
    chk({tag, ".cycles"}, 32'(cycles), 32'(m_cycles));
    chk({tag, ".viol"}, 32'(viol), 32'(m_viol));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".code"}, 32'(err_code), 32'(m_code));
  endtask

  function automatic int decode(input logic [1:0] h, input logic [1:0] c);
    for (int i = 0; i < 5; i++)
      if (pat_h[i] == h && pat_c[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 7; m_dwell = 0; m_cycles = 0; m_viol = 0;
    m_err = 0; m_code = 0; m_prevx = 0;
  endtask

  task automatic model_tick(input logic [1:0] h, input logic [1:0] c, input logic x);
    int s, code;
    s = decode(h, c);
    code = 0;
    if (m_state == 7) begin
      if (s < 0) code = 1;
      else begin m_state = s; m_dwell = 1; end
    end else if (s < 0) begin
      code = 1; m_state = 7; m_dwell = 0;
    end else if (s == m_state) begin
      m_dwell = (m_dwell >= 15) ? 15 : m_dwell + 1;
    end else if (s == (m_state + 1) % 5) begin
      if ((m_state == 1 || m_state == 4) && m_dwell < 3) code = 3;
      else if (m_state == 2 && m_dwell < 2) code = 4;
      else if (m_state == 0 && m_prevx == 0) code = 5;
      if (m_state == 4) m_cycles = (m_cycles + 1) % 65536;
      m_state = s; m_dwell = 1;
    end else begin
      code = 2; m_state = s; m_dwell = 1;
    end
    m_prevx = x;
    m_viol = (code != 0);
    if (code != 0 && m_err == 0) begin m_err = 1; m_code = code; end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    clr = 1'b1; slowclk = 1'b0;
    repeat (n) @(negedge clk);
    clr = 1'b0;
    model_reset();
    chk_all("reset");
  endtask

  // One slowclk pulse: high for hi clks, low for lo clks; outputs checked every clk.
  task automatic do_tick(input logic [1:0] h, input logic [1:0] c, input logic x,
                         input int hi, input int lo, input string tag);
    hwy = h; cntry = c; X = x; slowclk = 1'b1;
    model_tick(h, c, x);
    @(negedge clk);
    chk_all(tag);
    m_viol = 0;
    for (int i = 1; i < hi; i++) begin
      @(negedge clk);
      chk({tag, ".hold_dwell"}, 32'(dwell), 32'(m_dwell));
      chk({tag, ".hold_viol"}, 32'(viol), 32'(0));
    end
    slowclk = 1'b0;
    repeat (lo) @(negedge clk);
    chk({tag, ".lo_viol"}, 32'(viol), 32'(0));
  endtask

  task automatic st(input int s, input logic x, input int n, input string tag);
    for (int i = 0; i < n; i++) do_tick(pat_h[s], pat_c[s], x, 1, 1, tag);
  endtask

  initial begin
    model_reset();
    // T1: full legal cycle
    do_reset(10);
    st(0, 1'b0, 2, "t1_s0");
    st(0, 1'b1, 1, "t1_s0x");
    st(1, 1'b0, 3, "t1_s1");
    st(2, 1'b0, 2, "t1_s2");
    st(3, 1'b0, 3, "t1_s3");
    st(4, 1'b0, 3, "t1_s4");
    st(0, 1'b0, 1, "t1_end");
    chk("t1_err", 32'(err), 32'(0));
    chk("t1_cycles", 32'(cycles), 32'(1));
    chk("t1_state", 32'(state_id), 32'(0));
    chk("t1_dwell", 32'(dwell), 32'(1));

    // T2: conflict from S0, then resync
    do_tick(2'd2, 2'd2, 1'b0, 1, 1, "t2_conf");
    chk("t2_code", 32'(err_code), 32'(1));
    chk("t2_state", 32'(state_id), 32'(7));
    st(0, 1'b0, 1, "t2_sync");
    chk("t2_state0", 32'(state_id), 32'(0));

    // T3: short yellow then short all-red
    do_reset(2);
    st(0, 1'b1, 1, "t3_s0");
    st(1, 1'b0, 2, "t3_s1");
    st(2, 1'b0, 1, "t3_s2");
    chk("t3_code", 32'(err_code), 32'(3));
    st(3, 1'b0, 1, "t3_s3");
    chk("t3_code_held", 32'(err_code), 32'(3));

    // T4: unrequested, then illegal transition
    do_reset(2);
    st(0, 1'b0, 3, "t4_s0");
    st(1, 1'b0, 1, "t4_s1");
    chk("t4_code5", 32'(err_code), 32'(5));
    do_reset(2);
    st(0, 1'b1, 1, "t4b_s0");
    st(3, 1'b0, 1, "t4b_s3");
    chk("t4_code2", 32'(err_code), 32'(2));

    // T5: dwell saturation, then clr coinciding with a tick
    do_reset(2);
    st(0, 1'b1, 1, "t5_s0");
    st(1, 1'b0, 3, "t5_s1");
    st(2, 1'b0, 20, "t5_s2");
    chk("t5_sat", 32'(dwell), 32'(15));
    hwy = 2'd0; cntry = 2'd0; slowclk = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; slowclk = 1'b0;
    model_reset();
    chk_all("t5_clr");
    @(negedge clk);

    // T6: long slowclk high -> single tick each
    st(0, 1'b1, 1, "t6_s0");
    do_tick(pat_h[0], pat_c[0], 1'b1, 8, 2, "t6_long");
    do_tick(pat_h[0], pat_c[0], 1'b1, 6, 3, "t6_long2");
    chk("t6_dwell", 32'(dwell), 32'(3));

    // Random: biased toward legal progress, with occasional faults
    do_reset(2);
    for (int k = 0; k < 250; k++) begin
      int r, s;
      logic [1:0] h, c;
      r = $urandom_range(0, 9);
      s = (m_state == 7) ? 0 : m_state;
      if (r >= 5 && r <= 7) s = (s + 1) % 5;
      if (r == 9) s = $urandom_range(0, 4);
      h = pat_h[s]; c = pat_c[s];
      if (r == 8) begin h = 2'($urandom_range(0, 3)); c = 2'($urandom_range(0, 3)); end
      do_tick(h, c, 1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 3), "rand");
      if (k % 60 == 59) do_reset(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
